// File: rtl/signed_addsub_pkg.sv
// Shared types and constants for the serial signed adder/subtractor.
// Holds the controller state encoding and the saturation constant helpers.
package signed_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returned 64 bits wide; callers truncate to their WIDTH (WIDTH <= 64).
  function automatic logic [63:0] sat_max_pos(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_max_neg(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/signed_addsub_serial_digit.sv
// One DIGIT-bit ripple-carry slice; also exposes the carry into its top bit
// so the caller can form signed overflow on the most significant digit.
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] s_d,
  output logic             cout,
  output logic             c_top_in
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
    assign c[i + 1] = (a_d[i] & b_d[i]) | (a_d[i] & c[i]) | (b_d[i] & c[i]);
  end

  assign cout     = c[DIGIT];
  assign c_top_in = c[DIGIT-1];

endmodule

// File: rtl/signed_addsub_serial.sv
// Digit-serial signed add/subtract with valid/ready on both sides.
// Define SIGNED_ADDSUB_SAT_EN to saturate the result on signed overflow.
module signed_addsub_serial
  import signed_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             carry_out
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(N - 1);
  localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(sat_max_pos(WIDTH));
  localparam logic [WIDTH-1:0] MAX_NEG = WIDTH'(sat_max_neg(WIDTH));

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, ovf_q, cout_q;

  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic             c_out_dig, c_top_dig;
  logic             last_dig;

  assign a_dig    = a_q[cnt_q*DIGIT +: DIGIT];
  assign b_dig    = b_q[cnt_q*DIGIT +: DIGIT];
  assign last_dig = (cnt_q == LAST);

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d      (a_dig),
    .b_d      (b_dig),
    .cin      (carry_q),
    .s_d      (s_dig),
    .cout     (c_out_dig),
    .c_top_in (c_top_dig)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_dig) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          sum_q[cnt_q*DIGIT +: DIGIT] <= s_dig;
          carry_q <= c_out_dig;
          cnt_q   <= cnt_q + 1'b1;
          if (last_dig) begin
            cout_q <= c_out_dig;
            ovf_q  <= c_top_dig ^ c_out_dig;
`ifdef SIGNED_ADDSUB_SAT_EN
            if (c_top_dig ^ c_out_dig)
              sum_q <= a_q[WIDTH-1] ? MAX_NEG : MAX_POS;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = sum_q;
  assign overflow  = ovf_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_signed_addsub_serial.sv
// Self-checking bench for signed_addsub_serial (WIDTH=16, DIGIT=4) against
// an arithmetic reference model; honours SIGNED_ADDSUB_SAT_EN if defined.
module tb_signed_addsub_serial;

  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         overflow;
  logic         carry_out;

  int n_tests = 0;
  int n_fail  = 0;

  signed_addsub_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  // Reference: signed result from integer arithmetic, carry from unsigned compare.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input bit ms,
                                output logic [W-1:0] r, output bit ov, output bit co);
    longint sa, sb, sr;
    longint ua, ub;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = longint'(ma);
    ub = longint'(mb);
    sr = ms ? sa - sb : sa + sb;
    ov = (sr > 32767) || (sr < -32768);
    co = ms ? (ua >= ub) : (ua + ub > 65535);
    r  = sr[W-1:0];
`ifdef SIGNED_ADDSUB_SAT_EN
    if (ov) r = (sa < 0) ? 16'h8000 : 16'h7FFF;
`endif
  endfunction

  // Drives one operation through both handshakes; returns outputs and latency.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input bit is,
                        output logic [W-1:0] r, output bit ov, output bit co, output int lat);
    int guard;
    @(negedge clk);
    a = ia; b = ib; sub = is; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    r = sum; ov = overflow; co = carry_out;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    #12;
    n_tests++;
    if ({sum, overflow, carry_out, out_valid} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got sum=%h ovf=%b co=%b ov=%b, need all 0",
               sum, overflow, carry_out, out_valid);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, need 1", in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_in_ready: got %b, need 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4] = '{16'hFFFD, 16'h7FFF, 16'h8000, 16'h0003};
    logic [W-1:0] vb [4] = '{16'h0005, 16'h0001, 16'h0001, 16'h0005};
    bit           vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef SIGNED_ADDSUB_SAT_EN
    logic [W-1:0] er [4] = '{16'h0002, 16'h7FFF, 16'h8000, 16'hFFFE};
`else
    logic [W-1:0] er [4] = '{16'h0002, 16'h8000, 16'h7FFF, 16'hFFFE};
`endif
    bit           eo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit           ec [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] r;
    bit ov, co;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vs[i], r, ov, co, lat);
      n_tests++;
      if (r !== er[i]) begin
        n_fail++;
        $display("FAIL directed_sum[%0d]: got %h, need %h", i, r, er[i]);
      end
      n_tests++;
      if (ov !== eo[i] || co !== ec[i]) begin
        n_fail++;
        $display("FAIL directed_flags[%0d]: got ovf=%b co=%b, need ovf=%b co=%b",
                 i, ov, co, eo[i], ec[i]);
      end
      n_tests++;
      if (lat != N) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d, need %0d", i, lat, N);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, r, er;
    bit rs, ov, co, eov, eco;
    int lat;
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) ra = 16'h8000;
      if (i % 8 == 1) rb = 16'h7FFF;
      if (i % 8 == 2) rb = 16'h0000;
      model(ra, rb, rs, er, eov, eco);
      run_op(ra, rb, rs, r, ov, co, lat);
      n_tests++;
      if (r !== er || ov !== eov || co !== eco || lat != N) begin
        n_fail++;
        $display("FAIL random[%0d] %h %s %h: got sum=%h ovf=%b co=%b lat=%0d, need sum=%h ovf=%b co=%b lat=%0d",
                 i, ra, rs ? "-" : "+", rb, r, ov, co, lat, er, eov, eco, N);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] er;
    bit eov, eco;
    int guard;
    model(16'h1357, 16'h2468, 1'b1, er, eov, eco);
    @(negedge clk);
    a = 16'h1357; b = 16'h2468; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    for (int c = 0; c < 5; c++) begin
      a = 16'($urandom); b = 16'($urandom);
      @(negedge clk);
      n_tests++;
      if (sum !== er || overflow !== eov || carry_out !== eco || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got sum=%h ovf=%b co=%b ov=%b ir=%b, need sum=%h ovf=%b co=%b ov=1 ir=0",
                 c, sum, overflow, carry_out, out_valid, in_ready, er, eov, eco);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got ir=%b ov=%b, need ir=1 ov=0", in_ready, out_valid);
    end
  endtask

  // Observation queues filled by the posedge monitor during back-to-back traffic.
  bit           mon_en = 1'b0;
  int           cyc = 0;
  int           acc_t [$];
  logic [W-1:0] exp_r [$];
  bit           exp_o [$];
  bit           exp_c [$];
  logic [W-1:0] obs_r [$];
  bit           obs_o [$];
  bit           obs_c [$];

  always @(posedge clk) begin
    if (mon_en) begin
      logic [W-1:0] mr;
      bit mo, mc;
      cyc++;
      if (in_valid && in_ready) begin
        model(a, b, sub, mr, mo, mc);
        acc_t.push_back(cyc);
        exp_r.push_back(mr); exp_o.push_back(mo); exp_c.push_back(mc);
      end
      if (out_valid && out_ready) begin
        obs_r.push_back(sum); obs_o.push_back(overflow); obs_c.push_back(carry_out);
      end
    end
  end

  task automatic test_back_to_back();
    @(negedge clk);
    mon_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    mon_en = 1'b0; out_ready = 1'b0;
    n_tests++;
    if (acc_t.size() < 6 || obs_r.size() != exp_r.size()) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d accepts %0d results, need >=6 accepts and equal results",
               acc_t.size(), obs_r.size());
    end
    for (int i = 1; i < acc_t.size(); i++) begin
      n_tests++;
      if (acc_t[i] - acc_t[i-1] != N + 2) begin
        n_fail++;
        $display("FAIL b2b_spacing[%0d]: got %0d cycles, need %0d", i, acc_t[i] - acc_t[i-1], N + 2);
      end
    end
    for (int i = 0; i < obs_r.size() && i < exp_r.size(); i++) begin
      n_tests++;
      if (obs_r[i] !== exp_r[i] || obs_o[i] !== exp_o[i] || obs_c[i] !== exp_c[i]) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: got sum=%h ovf=%b co=%b, need sum=%h ovf=%b co=%b",
                 i, obs_r[i], obs_o[i], obs_c[i], exp_r[i], exp_o[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] r;
    bit ov, co;
    int lat;
    @(negedge clk);
    a = 16'h7FFF; b = 16'h7FFF; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({sum, overflow, carry_out, out_valid} !== 19'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_outputs: got sum=%h ovf=%b co=%b ov=%b ir=%b, need zeros and ir=1",
               sum, overflow, carry_out, out_valid, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_output: got out_valid=%b, need 0", out_valid);
    end
    run_op(16'h1234, 16'h1111, 1'b0, r, ov, co, lat);
    n_tests++;
    if (r !== 16'h2345 || ov !== 1'b0 || co !== 1'b0 || lat != N) begin
      n_fail++;
      $display("FAIL abort_next_op: got sum=%h ovf=%b co=%b lat=%0d, need sum=2345 ovf=0 co=0 lat=%0d",
               r, ov, co, lat, N);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_addsub_serial.md
# signed_addsub_serial

Parametrised, multi-cycle signed two's-complement adder/subtractor. It processes WIDTH-bit operands DIGIT bits per clock and reports the result with overflow and carry-out. It generalises the team's fixed 4-bit combinational signed adder to arbitrary width, adds a subtract mode, and uses a valid/ready handshake on both sides. It sits in arithmetic datapaths where area matters more than latency.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. N = WIDTH/DIGIT digit cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and sub are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  signed operand A.
- b  input  WIDTH  signed operand B.
- sub  input  1  0: A+B; 1: A−B.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  signed result (wrapped, or saturated per Configuration).
- overflow  output  1  signed overflow occurred.
- carry_out  output  1  carry out of the MSB (unsigned carry; for subtraction, 1 means no borrow).

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE→RUN on an in_valid && in_ready edge:
  - latch a.
  - latch b, or ~b when sub=1.
  - set the carry register to sub.
  - set the digit counter to 0.
- Each RUN edge:
  - add digit i of A, B' and the carry using sub-module addsub_digit.
  - write the digit to sum[i*DIGIT +: DIGIT].
  - update the carry register.
  - on the last digit (i = N−1), also capture the carry into the MSB (c_msb_in) and the carry out of the MSB.
- RUN→DONE after digit N−1 is processed.
- DONE→IDLE on an out_valid && out_ready edge. A new operation cannot be accepted in the same cycle.
- overflow = c_msb_in XOR carry_out. carry_out = final carry.
- Once latched, result outputs stay stable through DONE regardless of out_ready.
- Operand inputs are ignored outside the IDLE accept edge.
- Asynchronous reset, including mid-RUN or mid-DONE, aborts any operation with no output produced. All of the following go to 0:
  - state → IDLE
  - sum, overflow, carry_out, out_valid
  - counter, carry register
- in_ready is combinational from state; it reads 1 during and after reset.

## Timing
- Accept at edge k. Digits are processed at edges k+1 … k+N. out_valid is high after edge k+N (latency N cycles).
- Earliest output handshake is edge k+N+1. Next accept is at edge k+N+2 or later. Maximum throughput is one operation per N+2 cycles.
- With DIGIT=WIDTH (N=1), out_valid rises one edge after accept.
- No combinational path from inputs to sum/overflow/carry_out. out_valid and in_ready depend only on state.

## Configuration
- SIGNED_ADDSUB_SAT_EN defined:
  - when overflow=1, sum is forced to the saturation value on the last RUN edge:
    - 0x7FF…F (max positive) if A's MSB=0.
    - 0x800…0 (max negative) if A's MSB=1.
  - overflow and carry_out still report the raw values.
- Not defined: sum is the wrapped modulo-2^WIDTH result.

## Structure
- Shared package signed_addsub_pkg holds:
  - the state enum (IDLE, RUN, DONE).
  - functions for the max-positive and max-negative constants given WIDTH.
- Counter width is max(1, $clog2(N)).
- Sub-module addsub_digit (parameter DIGIT) is a combinational DIGIT-bit ripple of full adders.
  - Inputs: a_d, b_d, cin.
  - Outputs: s_d, cout, c_top_in (the carry into the top bit).

## Test plan
All scenarios use WIDTH=16, DIGIT=4.
- 0xFFFD + 0x0005, sub=0 → sum=0x0002, overflow=0, carry_out=1. out_valid exactly 4 cycles after accept.
- 0x7FFF + 0x0001 → overflow=1. sum=0x8000 (0x7FFF with SIGNED_ADDSUB_SAT_EN).
- 0x8000 − 0x0001, sub=1 → overflow=1, carry_out=1. sum=0x7FFF (0x8000 with SIGNED_ADDSUB_SAT_EN).
- 0x0003 − 0x0005 → sum=0xFFFE, overflow=0, carry_out=0.
- out_ready held low 5 cycles in DONE → sum/overflow stable and in_ready=0. After the handshake, in_ready=1 on the next cycle. Back-to-back operations are spaced by exactly 6 cycles.
- rst_n pulsed low 2 cycles after accept → all outputs 0, in_ready=1. The next operation 0x1234 + 0x1111 yields 0x2345.
